// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse packet decoder and cursor tracker.
// Two-stage pipeline: capture a verified 3-byte packet, then apply the
// clamped movement and button state to the registered cursor outputs.
module ps2_mouse_cursor #(
   parameter int X_MAX  = 639,
   parameter int Y_MAX  = 479,
   parameter int X_INIT = 320,
   parameter int Y_INIT = 240
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_ready,
   input  logic [32:0] q,
   output logic [9:0]  cursor_x,
   output logic [9:0]  cursor_y,
   output logic        btn_left,
   output logic        btn_right,
   output logic        btn_middle,
   output logic        left_click,
   output logic        right_click,
   output logic        update,
   output logic        sync_err
);

   localparam logic signed [11:0] X_LIM = 12'(X_MAX);
   localparam logic signed [11:0] Y_LIM = 12'(Y_MAX);

   // Start/parity/stop framing bits are checked upstream and not needed here.
   logic unused_q_bits;
   assign unused_q_bits = ^{q[32:31], q[22:20], q[11:9], q[0]};

   logic       cap_valid;
   logic [7:0] byte0;
   logic [7:0] byte1;
   logic [7:0] byte2;

   logic signed [11:0] dx;
   logic signed [11:0] dy;
   logic signed [11:0] nx;
   logic signed [11:0] ny;
   logic [9:0]         clamped_x;
   logic [9:0]         clamped_y;

   // Saturate a signed position into the legal range [0, lim].
   function automatic logic [9:0] clamp_pos(input logic signed [11:0] v,
                                            input logic signed [11:0] lim);
      logic [9:0] r;
      if (v < 12'sd0) begin
         r = 10'd0;
      end else if (v > lim) begin
         r = lim[9:0];
      end else begin
         r = v[9:0];
      end
      return r;
   endfunction

   // Capture stage: latch the packet bytes only on the controller strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_valid <= 1'b0;
         byte0     <= 8'd0;
         byte1     <= 8'd0;
         byte2     <= 8'd0;
      end else begin
         cap_valid <= data_ready;
         if (data_ready) begin
            byte0 <= q[8:1];
            byte1 <= q[19:12];
            byte2 <= q[30:23];
         end
      end
   end

   // Movement math: sign-extended deltas (zeroed on overflow), screen Y inverted, then clamped.
   always_comb begin
      dx = 12'sd0;
      dy = 12'sd0;
      if (!byte0[6]) begin
         dx = {{3{byte0[4]}}, byte0[4], byte1};
      end
      if (!byte0[7]) begin
         dy = {{3{byte0[5]}}, byte0[5], byte2};
      end
      nx = $signed({2'b00, cursor_x}) + dx;
      ny = $signed({2'b00, cursor_y}) - dy;
      clamped_x = clamp_pos(nx, X_LIM);
      clamped_y = clamp_pos(ny, Y_LIM);
   end

   // Compute stage: commit accepted packets, or flag a bad sync bit instead.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cursor_x    <= 10'(X_INIT);
         cursor_y    <= 10'(Y_INIT);
         btn_left    <= 1'b0;
         btn_right   <= 1'b0;
         btn_middle  <= 1'b0;
         left_click  <= 1'b0;
         right_click <= 1'b0;
         update      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         left_click  <= 1'b0;
         right_click <= 1'b0;
         update      <= 1'b0;
         sync_err    <= 1'b0;
         if (cap_valid) begin
            if (byte0[3]) begin
               cursor_x    <= clamped_x;
               cursor_y    <= clamped_y;
               btn_left    <= byte0[0];
               btn_right   <= byte0[1];
               btn_middle  <= byte0[2];
               left_click  <= byte0[0] & ~btn_left;
               right_click <= byte0[1] & ~btn_right;
               update      <= 1'b1;
            end else begin
               sync_err    <= 1'b1;
            end
         end
      end
   end

endmodule
